rca_att_prog_ctrl: RTL and testbench
====================================

# rca_att_prog_ctrl

Programming controller for the Accelerator Trigger Table (ATT). It arbitrates trigger-install requests from the hardware profiler and explicit program/invalidate requests from the CPU, allocates an RCA slot, and sequences the per-field ATT writes. Writes are ordered invalidate, sbb_addr, loop_start_addr, validate, and each sequence starts only when the ATT is not injecting and the target RCA is idle. The block sits between the profiler/CPU control unit and the ATT field-write port.

## Interface
- NUM_RCAS, 4, number of RCA slots/ATT entries (power of 2)
- XLEN, 32, address width
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-low
- prof_req_valid  in  1  profiler proposes a trigger
- prof_req_ready  out  1  profiler request accepted this cycle
- prof_loop_start  in  XLEN  loop start address
- prof_sbb_addr  in  XLEN  address following the accelerated block
- cpu_req_valid  in  1  CPU request
- cpu_req_ready  out  1  CPU request accepted this cycle
- cpu_op  in  1  0 = PROGRAM, 1 = INVALIDATE
- cpu_slot  in  log2(NUM_RCAS)  target slot
- cpu_loop_start  in  XLEN  loop start address
- cpu_sbb_addr  in  XLEN  sbb address
- att_busy  in  1  ATT is mid-injection (not in STATE_NO_TRIGGER)
- rca_busy  in  NUM_RCAS  per-slot accelerator executing
- att_wr_en  out  1  field write strobe
- att_wr_rca_addr  out  log2(NUM_RCAS)  entry index
- att_wr_field_id  out  2  0 = SBB_ADDR, 1 = LOOP_START_ADDR, 2 = VALID
- att_wr_value  out  XLEN  field value
- slot_valid  out  NUM_RCAS  shadow of the ATT valid bits
- slot_locked  out  NUM_RCAS  slot owned by the CPU
- done  out  1  one-cycle completion pulse
- done_slot  out  log2(NUM_RCAS)  slot affected
- done_status  out  2  0 = OK, 1 = DUPLICATE, 2 = NO_SLOT

## Operation
**States:** IDLE, WAIT_QUIET, INVAL, WR_SBB, WR_LOOP, VALIDATE.

**Arbitration (IDLE only):**
- Two-way round-robin on the `last_grant` bit. If only one requester is valid, it wins.
- `cpu_req_ready = IDLE & cpu_req_valid & (!prof_req_valid | last_grant==PROF)`. `prof_req_ready` is the mirror of this.
- Outside IDLE, both ready outputs are 0.

**Accept:**
- On accept, capture op, slot, and both addresses, and update `last_grant`.
- **CPU PROGRAM:** slot = `cpu_slot`; set `slot_locked[slot]`.
- **CPU INVALIDATE:** slot = `cpu_slot`; run WAIT_QUIET, then INVAL, then return to IDLE.
  - Clears `slot_valid` and `slot_locked` for the slot.
  - Completes with done/OK.
- **Profiler, duplicate case:** if `prof_loop_start` equals the shadow loop address of any valid slot, make no writes. Stay in IDLE and pulse done/DUPLICATE with that slot in the next cycle.
- **Profiler, slot selection:**
  - Take the lowest-index slot that is both invalid and unlocked.
  - Otherwise take the victim pointer, skipping locked slots (scan upward with wrap).
  - If all slots are locked: no writes; pulse done/NO_SLOT in the next cycle, with `done_slot` = 0.
  - After an eviction, the victim pointer moves to slot+1 (mod NUM_RCAS).

**WAIT_QUIET:** hold until `!att_busy & !rca_busy[slot]`. There is no timeout.

**Write sequence:** one write per cycle, with `att_wr_en` = 1 in each of these states.
- INVAL: VALID = 0.
- WR_SBB: SBB_ADDR.
- WR_LOOP: LOOP_START_ADDR.
- VALIDATE: VALID = 1. Set `slot_valid[slot]` and pulse done/OK in this same cycle.
- Values are zero-extended into `att_wr_value`.

**Shadow registers:** the block keeps a shadow loop_start per slot for duplicate detection.

## Timing
**Reset:**
- State IDLE.
- All outputs 0.
- `slot_valid` = 0, `slot_locked` = 0, victim pointer = 0, shadows = 0.
- `last_grant` = PROF, so the CPU wins the first tie.

**Latency:**
- Accept at cycle T.
- WAIT_QUIET at T+1; if quiet at T+1, writes occur at T+2 through T+5.
- done at T+5; IDLE and ready again at T+6.
- Each cycle of quiet stall adds 1.

**Edge cases:**
- INVALIDATE: write at T+2, done at T+2.
- DUPLICATE / NO_SLOT: done at T+1, ready again at T+1.
- `att_busy` or `rca_busy` rising after WAIT_QUIET is ignored, because the entry is already invalid, so the ATT cannot trigger on it.
- Reset mid-sequence: returns to the reset values immediately. A partially written ATT entry is acceptable because the ATT resets in the same reset domain.
- CPU PROGRAM on an already-valid slot still performs INVAL first.

## Structure
**Package `rca_config` additions:**
- `att_field_t` enum, with the codes above.
- `att_prog_op_t`.
- `att_prog_status_t`.
- Packed `att_wr_t` struct carrying en, rca_addr, field_id and value.

**Sub-module `rca_att_victim_sel` (combinational):**
- Inputs: valid mask, lock mask, pointer.
- Outputs: slot, found.
- Selection: priority over the free slots first, then a masked round-robin scan.

## Test plan
- **Profiler install, empty ATT:** profiler loop=0x100, sbb=0x180, quiet.
  - Accept at T.
  - Writes at T+2..T+5, in this order: (slot0, VALID, 0), (slot0, SBB, 0x180), (slot0, LOOP, 0x100), (slot0, VALID, 1).
  - done OK, slot 0, at T+5.
- **Simultaneous requests after reset:** both valid.
  - The CPU is granted first (PROGRAM slot 2).
  - The profiler is granted at the next IDLE.
  - `slot_locked` = 4'b0100.
- **Stall on busy:** `rca_busy[1]` = 1 for 3 cycles while reprogramming slot 1.
  - INVAL is delayed exactly 3 cycles.
  - `att_busy` pulses are also honored.
- **Duplicate proposal:** profiler re-proposes loop=0x100 while slot 0 is valid.
  - No `att_wr_en`.
  - done DUPLICATE, slot 0, at T+1.
- **Eviction:** all 4 slots valid, slot 0 locked, victim pointer 0.
  - The profiler evicts slot 1 and the pointer becomes 2.
  - With all slots locked: done NO_SLOT, no writes.
- **Async reset mid-WR_LOOP:** assert `rst` low.
  - Outputs are 0 immediately, state is IDLE.
  - `slot_valid` = 0 and ready recovers one cycle after deassertion.

Source files
------------

// File: rtl/rca_att_prog_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// rca_att_prog_ctrl_pkg
//
// Shared types for the Accelerator Trigger Table programming controller:
//   att_field_t        - ATT field selector driven on the field-write port
//   att_prog_op_t      - CPU request opcode (program / invalidate)
//   att_prog_status_t  - completion status reported with the done pulse
//   att_grant_t        - round-robin arbitration memory
//   att_prog_state_t   - controller sequencing states
//   att_wr_t           - packed bundle of one ATT field write, sized for the
//                        default configuration (ATT_NUM_RCAS / ATT_XLEN)
// ---------------------------------------------------------------------------
package rca_att_prog_ctrl_pkg;

  localparam int unsigned ATT_NUM_RCAS = 4;
  localparam int unsigned ATT_XLEN     = 32;
  localparam int unsigned ATT_SLOT_W   = $clog2(ATT_NUM_RCAS);

  typedef enum logic [1:0] {
    FIELD_SBB_ADDR        = 2'd0,
    FIELD_LOOP_START_ADDR = 2'd1,
    FIELD_VALID           = 2'd2
  } att_field_t;

  typedef enum logic {
    OP_PROGRAM    = 1'b0,
    OP_INVALIDATE = 1'b1
  } att_prog_op_t;

  typedef enum logic [1:0] {
    STATUS_OK        = 2'd0,
    STATUS_DUPLICATE = 2'd1,
    STATUS_NO_SLOT   = 2'd2
  } att_prog_status_t;

  typedef enum logic {
    GRANT_PROF = 1'b0,
    GRANT_CPU  = 1'b1
  } att_grant_t;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_WAIT_QUIET = 3'd1,
    ST_INVAL      = 3'd2,
    ST_WR_SBB     = 3'd3,
    ST_WR_LOOP    = 3'd4,
    ST_VALIDATE   = 3'd5
  } att_prog_state_t;

  typedef struct packed {
    logic                  en;
    logic [ATT_SLOT_W-1:0] rca_addr;
    att_field_t            field_id;
    logic [ATT_XLEN-1:0]   value;
  } att_wr_t;

endpackage

// File: rtl/rca_att_victim_sel.sv
// ---------------------------------------------------------------------------
// rca_att_victim_sel
//
// Combinational slot chooser for profiler-driven trigger installs.
//   valid_i : per-slot ATT valid shadow
//   lock_i  : per-slot CPU ownership
//   ptr_i   : round-robin victim pointer
//   slot_o  : chosen slot
//   found_o : a usable slot exists (0 when every slot is locked)
// ---------------------------------------------------------------------------
module rca_att_victim_sel #(
  parameter int unsigned NUM_RCAS = 4
) (
  input  logic [NUM_RCAS-1:0]         valid_i,
  input  logic [NUM_RCAS-1:0]         lock_i,
  input  logic [$clog2(NUM_RCAS)-1:0] ptr_i,
  output logic [$clog2(NUM_RCAS)-1:0] slot_o,
  output logic                        found_o
);

  localparam int unsigned SLOT_W = $clog2(NUM_RCAS);

  logic [NUM_RCAS-1:0] free_mask;
  logic [SLOT_W-1:0]   scan_idx;

  // A slot that is neither valid nor locked costs nothing to take, so those
  // win first, lowest index preferred (the downward loop leaves the lowest
  // hit as the final assignment). Only when no free slot exists do we evict:
  // scan upward from the victim pointer with wrap and take the first slot the
  // CPU has not locked. The pointer add wraps naturally because NUM_RCAS is
  // a power of two.
  always_comb begin
    free_mask = ~valid_i & ~lock_i;
    slot_o    = '0;
    found_o   = 1'b0;
    scan_idx  = '0;
    for (int i = int'(NUM_RCAS) - 1; i >= 0; i--) begin
      if (free_mask[i]) begin
        slot_o  = SLOT_W'(i);
        found_o = 1'b1;
      end
    end
    if (!found_o) begin
      for (int k = int'(NUM_RCAS) - 1; k >= 0; k--) begin
        scan_idx = ptr_i + SLOT_W'(k);
        if (!lock_i[scan_idx]) begin
          slot_o  = scan_idx;
          found_o = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/rca_att_prog_ctrl.sv
// ---------------------------------------------------------------------------
// rca_att_prog_ctrl
//
// Arbitrates trigger installs from the hardware profiler against explicit
// program/invalidate requests from the CPU, allocates an RCA slot and drives
// the ATT field-write port in the order invalidate, sbb_addr,
// loop_start_addr, validate.
//
// Ports:
//   clk_i, rst_ni                 clock, asynchronous active-low reset
//   prof_req_valid_i/_ready_o     profiler trigger proposal handshake
//   prof_loop_start_i, prof_sbb_addr_i
//   cpu_req_valid_i/_ready_o      CPU request handshake
//   cpu_op_i                      0 = PROGRAM, 1 = INVALIDATE
//   cpu_slot_i, cpu_loop_start_i, cpu_sbb_addr_i
//   att_busy_i                    ATT mid-injection
//   rca_busy_i                    per-slot accelerator executing
//   att_wr_en_o, att_wr_rca_addr_o, att_wr_field_id_o, att_wr_value_o
//                                 registered ATT field write
//   slot_valid_o, slot_locked_o   valid shadow / CPU ownership per slot
//   done_o, done_slot_o, done_status_o
//                                 one-cycle completion report
// ---------------------------------------------------------------------------
module rca_att_prog_ctrl
  import rca_att_prog_ctrl_pkg::*;
#(
  parameter int unsigned NUM_RCAS = ATT_NUM_RCAS,
  parameter int unsigned XLEN     = ATT_XLEN
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        prof_req_valid_i,
  output logic                        prof_req_ready_o,
  input  logic [XLEN-1:0]             prof_loop_start_i,
  input  logic [XLEN-1:0]             prof_sbb_addr_i,
  input  logic                        cpu_req_valid_i,
  output logic                        cpu_req_ready_o,
  input  logic                        cpu_op_i,
  input  logic [$clog2(NUM_RCAS)-1:0] cpu_slot_i,
  input  logic [XLEN-1:0]             cpu_loop_start_i,
  input  logic [XLEN-1:0]             cpu_sbb_addr_i,
  input  logic                        att_busy_i,
  input  logic [NUM_RCAS-1:0]         rca_busy_i,
  output logic                        att_wr_en_o,
  output logic [$clog2(NUM_RCAS)-1:0] att_wr_rca_addr_o,
  output logic [1:0]                  att_wr_field_id_o,
  output logic [XLEN-1:0]             att_wr_value_o,
  output logic [NUM_RCAS-1:0]         slot_valid_o,
  output logic [NUM_RCAS-1:0]         slot_locked_o,
  output logic                        done_o,
  output logic [$clog2(NUM_RCAS)-1:0] done_slot_o,
  output logic [1:0]                  done_status_o
);

  localparam int unsigned SLOT_W = $clog2(NUM_RCAS);

  att_prog_state_t  state_q;
  att_grant_t       last_grant_q;
  att_prog_op_t     op_q;
  logic [SLOT_W-1:0] slot_q;
  logic [SLOT_W-1:0] victim_q;
  logic [XLEN-1:0]  loop_q;
  logic [XLEN-1:0]  sbb_q;
  logic [NUM_RCAS-1:0] slot_valid_q;
  logic [NUM_RCAS-1:0] slot_locked_q;
  logic [XLEN-1:0]  shadow_loop_q [NUM_RCAS];

  logic              wr_en_q;
  logic [SLOT_W-1:0] wr_addr_q;
  att_field_t        wr_field_q;
  logic [XLEN-1:0]   wr_value_q;
  logic              done_q;
  logic [SLOT_W-1:0] done_slot_q;
  att_prog_status_t  done_status_q;

  logic              is_idle;
  logic              cpu_accept;
  logic              prof_accept;
  logic              dup_hit;
  logic [SLOT_W-1:0] dup_slot;
  logic [SLOT_W-1:0] sel_slot;
  logic              sel_found;

  // Two-way round robin: on a tie the requester that did not win last time
  // gets the grant; a lone requester always wins. Grants only happen in IDLE
  // so a sequence in flight is never disturbed.
  assign is_idle     = (state_q == ST_IDLE);
  assign cpu_accept  = is_idle & cpu_req_valid_i &
                       (~prof_req_valid_i | (last_grant_q == GRANT_PROF));
  assign prof_accept = is_idle & prof_req_valid_i &
                       (~cpu_req_valid_i | (last_grant_q == GRANT_CPU));

  // The profiler tends to re-propose loops it already installed. Compare the
  // proposal against the loop shadow of every valid slot; the lowest matching
  // slot is reported back as the duplicate.
  always_comb begin
    dup_hit  = 1'b0;
    dup_slot = '0;
    for (int i = int'(NUM_RCAS) - 1; i >= 0; i--) begin
      if (slot_valid_q[i] && (shadow_loop_q[i] == prof_loop_start_i)) begin
        dup_hit  = 1'b1;
        dup_slot = SLOT_W'(i);
      end
    end
  end

  rca_att_victim_sel #(
    .NUM_RCAS (NUM_RCAS)
  ) u_victim_sel (
    .valid_i (slot_valid_q),
    .lock_i  (slot_locked_q),
    .ptr_i   (victim_q),
    .slot_o  (sel_slot),
    .found_o (sel_found)
  );

  // Main sequencer. Outputs are registered, so the state register always
  // names the write currently visible on the ATT port: entering INVAL puts
  // the VALID=0 write on the port, entering VALIDATE puts VALID=1 plus the
  // done pulse on it. The entry is invalidated before any field changes, so
  // once we leave WAIT_QUIET a late att_busy/rca_busy cannot hurt and is not
  // looked at. Profiler requests that need no writes (duplicate, no slot)
  // finish straight from IDLE with a done pulse in the following cycle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= ST_IDLE;
      last_grant_q  <= GRANT_PROF;
      op_q          <= OP_PROGRAM;
      slot_q        <= '0;
      victim_q      <= '0;
      loop_q        <= '0;
      sbb_q         <= '0;
      slot_valid_q  <= '0;
      slot_locked_q <= '0;
      for (int i = 0; i < int'(NUM_RCAS); i++) begin
        shadow_loop_q[i] <= '0;
      end
      wr_en_q       <= 1'b0;
      wr_addr_q     <= '0;
      wr_field_q    <= FIELD_SBB_ADDR;
      wr_value_q    <= '0;
      done_q        <= 1'b0;
      done_slot_q   <= '0;
      done_status_q <= STATUS_OK;
    end else begin
      wr_en_q       <= 1'b0;
      wr_addr_q     <= '0;
      wr_field_q    <= FIELD_SBB_ADDR;
      wr_value_q    <= '0;
      done_q        <= 1'b0;
      done_slot_q   <= '0;
      done_status_q <= STATUS_OK;

      case (state_q)
        ST_IDLE: begin
          if (cpu_accept) begin
            last_grant_q <= GRANT_CPU;
            op_q         <= att_prog_op_t'(cpu_op_i);
            slot_q       <= cpu_slot_i;
            loop_q       <= cpu_loop_start_i;
            sbb_q        <= cpu_sbb_addr_i;
            if (att_prog_op_t'(cpu_op_i) == OP_PROGRAM) begin
              slot_locked_q[cpu_slot_i] <= 1'b1;
            end
            state_q <= ST_WAIT_QUIET;
          end else if (prof_accept) begin
            last_grant_q <= GRANT_PROF;
            op_q         <= OP_PROGRAM;
            loop_q       <= prof_loop_start_i;
            sbb_q        <= prof_sbb_addr_i;
            if (dup_hit) begin
              done_q        <= 1'b1;
              done_slot_q   <= dup_slot;
              done_status_q <= STATUS_DUPLICATE;
            end else if (!sel_found) begin
              done_q        <= 1'b1;
              done_slot_q   <= '0;
              done_status_q <= STATUS_NO_SLOT;
            end else begin
              slot_q <= sel_slot;
              if (slot_valid_q[sel_slot]) begin
                victim_q <= sel_slot + SLOT_W'(1);
              end
              state_q <= ST_WAIT_QUIET;
            end
          end
        end

        ST_WAIT_QUIET: begin
          if (!att_busy_i && !rca_busy_i[slot_q]) begin
            wr_en_q              <= 1'b1;
            wr_addr_q            <= slot_q;
            wr_field_q           <= FIELD_VALID;
            wr_value_q           <= '0;
            slot_valid_q[slot_q] <= 1'b0;
            if (op_q == OP_INVALIDATE) begin
              slot_locked_q[slot_q] <= 1'b0;
              done_q                <= 1'b1;
              done_slot_q           <= slot_q;
              done_status_q         <= STATUS_OK;
            end
            state_q <= ST_INVAL;
          end
        end

        ST_INVAL: begin
          if (op_q == OP_INVALIDATE) begin
            state_q <= ST_IDLE;
          end else begin
            wr_en_q    <= 1'b1;
            wr_addr_q  <= slot_q;
            wr_field_q <= FIELD_SBB_ADDR;
            wr_value_q <= sbb_q;
            state_q    <= ST_WR_SBB;
          end
        end

        ST_WR_SBB: begin
          wr_en_q    <= 1'b1;
          wr_addr_q  <= slot_q;
          wr_field_q <= FIELD_LOOP_START_ADDR;
          wr_value_q <= loop_q;
          state_q    <= ST_WR_LOOP;
        end

        ST_WR_LOOP: begin
          wr_en_q               <= 1'b1;
          wr_addr_q             <= slot_q;
          wr_field_q            <= FIELD_VALID;
          wr_value_q            <= XLEN'(1);
          slot_valid_q[slot_q]  <= 1'b1;
          shadow_loop_q[slot_q] <= loop_q;
          done_q                <= 1'b1;
          done_slot_q           <= slot_q;
          done_status_q         <= STATUS_OK;
          state_q               <= ST_VALIDATE;
        end

        ST_VALIDATE: begin
          state_q <= ST_IDLE;
        end

        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign cpu_req_ready_o   = cpu_accept;
  assign prof_req_ready_o  = prof_accept;
  assign att_wr_en_o       = wr_en_q;
  assign att_wr_rca_addr_o = wr_addr_q;
  assign att_wr_field_id_o = wr_field_q;
  assign att_wr_value_o    = wr_value_q;
  assign slot_valid_o      = slot_valid_q;
  assign slot_locked_o     = slot_locked_q;
  assign done_o            = done_q;
  assign done_slot_o       = done_slot_q;
  assign done_status_o     = done_status_q;

endmodule

// File: tb/tb_rca_att_prog_ctrl.sv
// ---------------------------------------------------------------------------
// tb_rca_att_prog_ctrl
//
// Directed bench for the ATT programming controller: reset values, the
// arbitration table, profiler installs, CPU program/invalidate, busy stalls,
// duplicate and no-slot completions, eviction order and async reset.
// ---------------------------------------------------------------------------
module tb_rca_att_prog_ctrl;

  logic        clk;
  logic        rstN;
  logic        profReqValid;
  logic        profReqReady;
  logic [31:0] profLoopStart;
  logic [31:0] profSbbAddr;
  logic        cpuReqValid;
  logic        cpuReqReady;
  logic        cpuOp;
  logic [1:0]  cpuSlot;
  logic [31:0] cpuLoopStart;
  logic [31:0] cpuSbbAddr;
  logic        attBusy;
  logic [3:0]  rcaBusy;
  logic        attWrEn;
  logic [1:0]  attWrRcaAddr;
  logic [1:0]  attWrFieldId;
  logic [31:0] attWrValue;
  logic [3:0]  slotValid;
  logic [3:0]  slotLocked;
  logic        done;
  logic [1:0]  doneSlot;
  logic [1:0]  doneStatus;

  int checkCount = 0;
  int passCount  = 0;
  int failCount  = 0;

  typedef struct {
    logic cpuValid;
    logic profValid;
    logic expCpuReady;
    logic expProfReady;
  } arbVec_t;

  typedef struct {
    logic [1:0]  field;
    logic [31:0] value;
    logic        done;
  } wrExp_t;

  arbVec_t arbTable [4];

  rca_att_prog_ctrl #(
    .NUM_RCAS (4),
    .XLEN     (32)
  ) dut (
    .clk_i             (clk),
    .rst_ni            (rstN),
    .prof_req_valid_i  (profReqValid),
    .prof_req_ready_o  (profReqReady),
    .prof_loop_start_i (profLoopStart),
    .prof_sbb_addr_i   (profSbbAddr),
    .cpu_req_valid_i   (cpuReqValid),
    .cpu_req_ready_o   (cpuReqReady),
    .cpu_op_i          (cpuOp),
    .cpu_slot_i        (cpuSlot),
    .cpu_loop_start_i  (cpuLoopStart),
    .cpu_sbb_addr_i    (cpuSbbAddr),
    .att_busy_i        (attBusy),
    .rca_busy_i        (rcaBusy),
    .att_wr_en_o       (attWrEn),
    .att_wr_rca_addr_o (attWrRcaAddr),
    .att_wr_field_id_o (attWrFieldId),
    .att_wr_value_o    (attWrValue),
    .slot_valid_o      (slotValid),
    .slot_locked_o     (slotLocked),
    .done_o            (done),
    .done_slot_o       (doneSlot),
    .done_status_o     (doneStatus)
  );

  // Free-running 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard stop in case something stalls the stimulus thread.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    checkCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end else begin
      passCount++;
    end
  endtask

  task automatic applyStimulus(input arbVec_t v);
    cpuReqValid  = v.cpuValid;
    profReqValid = v.profValid;
  endtask

  task automatic waitCycle();
    @(posedge clk);
    #1;
  endtask

  // Checks the four write cycles INVAL, SBB, LOOP, VALIDATE that follow the
  // last WAIT_QUIET cycle; entered one ns after the edge that ends it.
  task automatic expectProgram(input logic [1:0] slot, input logic [31:0] sbb,
                               input logic [31:0] loop, input string tag);
    wrExp_t expSeq [4];
    expSeq[0] = '{2'd2, 32'd0, 1'b0};
    expSeq[1] = '{2'd0, sbb,   1'b0};
    expSeq[2] = '{2'd1, loop,  1'b0};
    expSeq[3] = '{2'd2, 32'd1, 1'b1};
    for (int i = 0; i < 4; i++) begin
      waitCycle();
      checkOutput($sformatf("%s wrEn[%0d]", tag, i), attWrEn, 1'b1);
      checkOutput($sformatf("%s wrAddr[%0d]", tag, i), attWrRcaAddr, slot);
      checkOutput($sformatf("%s wrField[%0d]", tag, i), attWrFieldId, expSeq[i].field);
      checkOutput($sformatf("%s wrValue[%0d]", tag, i), attWrValue, expSeq[i].value);
      checkOutput($sformatf("%s done[%0d]", tag, i), done, expSeq[i].done);
      if (i == 3) begin
        checkOutput($sformatf("%s doneSlot", tag), doneSlot, slot);
        checkOutput($sformatf("%s doneStatus", tag), doneStatus, 2'd0);
      end
    end
  endtask

  task automatic runCpuProgram(input logic [1:0] slot, input logic [31:0] sbb,
                               input logic [31:0] loop, input string tag);
    cpuReqValid  = 1'b1;
    cpuOp        = 1'b0;
    cpuSlot      = slot;
    cpuSbbAddr   = sbb;
    cpuLoopStart = loop;
    #1 checkOutput({tag, " cpuReady"}, cpuReqReady, 1'b1);
    waitCycle();
    cpuReqValid = 1'b0;
    checkOutput({tag, " quietNoWrite"}, attWrEn, 1'b0);
    expectProgram(slot, sbb, loop, tag);
    waitCycle();
    checkOutput({tag, " idleNoWrite"}, attWrEn, 1'b0);
  endtask

  task automatic runProfProgram(input logic [1:0] expSlot, input logic [31:0] sbb,
                                input logic [31:0] loop, input string tag);
    profReqValid  = 1'b1;
    profSbbAddr   = sbb;
    profLoopStart = loop;
    #1 checkOutput({tag, " profReady"}, profReqReady, 1'b1);
    waitCycle();
    profReqValid = 1'b0;
    checkOutput({tag, " quietNoWrite"}, attWrEn, 1'b0);
    expectProgram(expSlot, sbb, loop, tag);
    waitCycle();
    checkOutput({tag, " idleNoWrite"}, attWrEn, 1'b0);
  endtask

  initial begin
    // Ready outputs seen from IDLE right after reset, CPU wins the tie.
    arbTable[0] = '{1'b0, 1'b0, 1'b0, 1'b0};
    arbTable[1] = '{1'b1, 1'b0, 1'b1, 1'b0};
    arbTable[2] = '{1'b0, 1'b1, 1'b0, 1'b1};
    arbTable[3] = '{1'b1, 1'b1, 1'b1, 1'b0};

    rstN          = 1'b0;
    profReqValid  = 1'b0;
    profLoopStart = '0;
    profSbbAddr   = '0;
    cpuReqValid   = 1'b0;
    cpuOp         = 1'b0;
    cpuSlot       = '0;
    cpuLoopStart  = '0;
    cpuSbbAddr    = '0;
    attBusy       = 1'b0;
    rcaBusy       = '0;

    // Reset values.
    waitCycle();
    waitCycle();
    checkOutput("rst wrEn", attWrEn, 1'b0);
    checkOutput("rst wrValue", attWrValue, 32'd0);
    checkOutput("rst done", done, 1'b0);
    checkOutput("rst slotValid", slotValid, 4'b0000);
    checkOutput("rst slotLocked", slotLocked, 4'b0000);
    checkOutput("rst cpuReady", cpuReqReady, 1'b0);
    checkOutput("rst profReady", profReqReady, 1'b0);
    rstN = 1'b1;
    waitCycle();

    // Arbitration table, each vector withdrawn before the next edge.
    for (int i = 0; i < 4; i++) begin
      applyStimulus(arbTable[i]);
      #1;
      checkOutput($sformatf("arb[%0d] cpuReady", i), cpuReqReady, arbTable[i].expCpuReady);
      checkOutput($sformatf("arb[%0d] profReady", i), profReqReady, arbTable[i].expProfReady);
      cpuReqValid  = 1'b0;
      profReqValid = 1'b0;
      waitCycle();
    end

    $display("[TB] profiler install into empty ATT");
    runProfProgram(2'd0, 32'h180, 32'h100, "install");
    checkOutput("install slotValid", slotValid, 4'b0001);

    $display("[TB] simultaneous CPU and profiler requests");
    cpuReqValid   = 1'b1;
    cpuOp         = 1'b0;
    cpuSlot       = 2'd2;
    cpuSbbAddr    = 32'h280;
    cpuLoopStart  = 32'h200;
    profReqValid  = 1'b1;
    profSbbAddr   = 32'h380;
    profLoopStart = 32'h300;
    #1;
    checkOutput("tie cpuReady", cpuReqReady, 1'b1);
    checkOutput("tie profReady", profReqReady, 1'b0);
    waitCycle();
    cpuReqValid = 1'b0;
    checkOutput("tie profHeldOff", profReqReady, 1'b0);
    checkOutput("tie slotLocked", slotLocked, 4'b0100);
    expectProgram(2'd2, 32'h280, 32'h200, "tieCpu");
    waitCycle();
    checkOutput("tie profReadyAtIdle", profReqReady, 1'b1);
    waitCycle();
    profReqValid = 1'b0;
    checkOutput("tieProf quietNoWrite", attWrEn, 1'b0);
    expectProgram(2'd1, 32'h380, 32'h300, "tieProf");
    waitCycle();
    checkOutput("tie slotValid", slotValid, 4'b0111);

    $display("[TB] duplicate proposal");
    profReqValid  = 1'b1;
    profLoopStart = 32'h100;
    profSbbAddr   = 32'h999;
    #1 checkOutput("dup profReady", profReqReady, 1'b1);
    waitCycle();
    profReqValid = 1'b0;
    checkOutput("dup done", done, 1'b1);
    checkOutput("dup doneSlot", doneSlot, 2'd0);
    checkOutput("dup doneStatus", doneStatus, 2'd1);
    checkOutput("dup noWrite", attWrEn, 1'b0);
    profReqValid = 1'b1;
    #1 checkOutput("dup readyAgain", profReqReady, 1'b1);
    profReqValid = 1'b0;
    waitCycle();
    checkOutput("dup doneCleared", done, 1'b0);
    checkOutput("dup stillNoWrite", attWrEn, 1'b0);

    $display("[TB] stall on rca_busy then att_busy while reprogramming slot 1");
    rcaBusy      = 4'b0010;
    cpuReqValid  = 1'b1;
    cpuOp        = 1'b0;
    cpuSlot      = 2'd1;
    cpuSbbAddr   = 32'h480;
    cpuLoopStart = 32'h400;
    #1 checkOutput("stall cpuReady", cpuReqReady, 1'b1);
    waitCycle();
    cpuReqValid = 1'b0;
    checkOutput("stall T+1 noWrite", attWrEn, 1'b0);
    for (int k = 2; k <= 5; k++) begin
      waitCycle();
      checkOutput($sformatf("stall T+%0d noWrite", k), attWrEn, 1'b0);
      if (k == 4) begin
        rcaBusy = 4'b0000;
        attBusy = 1'b1;
      end
      if (k == 5) begin
        attBusy = 1'b0;
      end
    end
    expectProgram(2'd1, 32'h480, 32'h400, "stall");
    waitCycle();
    checkOutput("stall slotLocked", slotLocked, 4'b0110);

    $display("[TB] CPU invalidate of slot 1");
    cpuReqValid = 1'b1;
    cpuOp       = 1'b1;
    cpuSlot     = 2'd1;
    #1 checkOutput("inval cpuReady", cpuReqReady, 1'b1);
    waitCycle();
    cpuReqValid = 1'b0;
    checkOutput("inval T+1 noWrite", attWrEn, 1'b0);
    waitCycle();
    checkOutput("inval wrEn", attWrEn, 1'b1);
    checkOutput("inval wrAddr", attWrRcaAddr, 2'd1);
    checkOutput("inval wrField", attWrFieldId, 2'd2);
    checkOutput("inval wrValue", attWrValue, 32'd0);
    checkOutput("inval done", done, 1'b1);
    checkOutput("inval doneSlot", doneSlot, 2'd1);
    checkOutput("inval doneStatus", doneStatus, 2'd0);
    waitCycle();
    checkOutput("inval T+3 noWrite", attWrEn, 1'b0);
    checkOutput("inval slotValid", slotValid, 4'b0101);
    checkOutput("inval slotLocked", slotLocked, 4'b0100);

    $display("[TB] fill table and exercise eviction");
    runCpuProgram(2'd0, 32'h580, 32'h500, "cpuSlot0");
    checkOutput("fill slotLocked", slotLocked, 4'b0101);
    runProfProgram(2'd1, 32'h680, 32'h600, "freeSlot1");
    runProfProgram(2'd3, 32'h780, 32'h700, "freeSlot3");
    checkOutput("fill slotValid", slotValid, 4'b1111);
    runProfProgram(2'd1, 32'h880, 32'h800, "evict1");
    runProfProgram(2'd3, 32'h980, 32'h900, "evict3");
    runCpuProgram(2'd1, 32'hA80, 32'hA00, "lock1");
    runCpuProgram(2'd3, 32'hB80, 32'hB00, "lock3");
    checkOutput("allLocked slotLocked", slotLocked, 4'b1111);

    profReqValid  = 1'b1;
    profLoopStart = 32'hC00;
    profSbbAddr   = 32'hC80;
    #1 checkOutput("noSlot profReady", profReqReady, 1'b1);
    waitCycle();
    profReqValid = 1'b0;
    checkOutput("noSlot done", done, 1'b1);
    checkOutput("noSlot doneSlot", doneSlot, 2'd0);
    checkOutput("noSlot doneStatus", doneStatus, 2'd2);
    checkOutput("noSlot noWrite", attWrEn, 1'b0);
    waitCycle();
    checkOutput("noSlot stillNoWrite", attWrEn, 1'b0);

    $display("[TB] asynchronous reset during WR_LOOP");
    cpuReqValid  = 1'b1;
    cpuOp        = 1'b0;
    cpuSlot      = 2'd2;
    cpuSbbAddr   = 32'hD80;
    cpuLoopStart = 32'hD00;
    #1 checkOutput("arst cpuReady", cpuReqReady, 1'b1);
    waitCycle();
    cpuReqValid = 1'b0;
    waitCycle();
    waitCycle();
    waitCycle();
    checkOutput("arst inWrLoop wrEn", attWrEn, 1'b1);
    checkOutput("arst inWrLoop wrField", attWrFieldId, 2'd1);
    #2 rstN = 1'b0;
    #1;
    checkOutput("arst wrEn", attWrEn, 1'b0);
    checkOutput("arst wrValue", attWrValue, 32'd0);
    checkOutput("arst slotValid", slotValid, 4'b0000);
    checkOutput("arst slotLocked", slotLocked, 4'b0000);
    checkOutput("arst done", done, 1'b0);
    waitCycle();
    rstN = 1'b1;
    waitCycle();
    cpuReqValid  = 1'b1;
    profReqValid = 1'b1;
    #1;
    checkOutput("arst cpuReadyRecovered", cpuReqReady, 1'b1);
    checkOutput("arst profLosesTie", profReqReady, 1'b0);
    cpuReqValid  = 1'b0;
    profReqValid = 1'b0;
    waitCycle();
    checkOutput("arst slotValidAfter", slotValid, 4'b0000);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
